// File: rtl/sync_counter_monitor.sv
// Passive checker for a synchronous enable counter: predicts each next count,
// flags deviations, resynchronises, and keeps saturating error/wrap tallies.
module sync_counter_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    output logic             err,
    output logic             err_seen,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_count,
    output logic             locked,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TALLY_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    state_t           st;
    logic [WIDTH-1:0] ref_cnt;
    logic             ref_en;
    logic [WIDTH-1:0] exp_cnt;

    assign exp_cnt = ref_en ? WIDTH'(ref_cnt + 1'b1) : ref_cnt;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            ref_cnt    <= '0;
            ref_en     <= 1'b0;
            err        <= 1'b0;
            err_seen   <= 1'b0;
            err_count  <= '0;
            wrap       <= 1'b0;
            wrap_count <= '0;
            locked     <= 1'b0;
        end else begin
            err     <= 1'b0;
            wrap    <= 1'b0;
            ref_cnt <= count;
            ref_en  <= en;
            case (st)
                IDLE: begin
                    // the counter shares our reset, so it must start at zero
                    if (count != '0) begin
                        err      <= 1'b1;
                        err_seen <= 1'b1;
                        if (err_count != TALLY_MAX)
                            err_count <= err_count + 1'b1;
                    end
                    st     <= CHECK;
                    locked <= 1'b1;
                end
                CHECK: begin
                    if (count != exp_cnt) begin
                        err      <= 1'b1;
                        err_seen <= 1'b1;
                        if (err_count != TALLY_MAX)
                            err_count <= err_count + 1'b1;
                        st     <= RESYNC;
                        locked <= 1'b0;
                    end else begin
                        if (ref_en && ref_cnt == CNT_MAX) begin
                            wrap <= 1'b1;
                            if (wrap_count != TALLY_MAX)
                                wrap_count <= wrap_count + 1'b1;
                        end
                        locked <= 1'b1;
                    end
                end
                RESYNC: begin
                    // skip one compare so a single bad value costs one error
                    st     <= CHECK;
                    locked <= 1'b1;
                end
                default: begin
                    st     <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_counter_monitor.sv
// Bench for sync_counter_monitor: drives a modelled counter with optional
// faults and compares every output against a behavioural model.
module tb_sync_counter_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] count = 4'd0;
    logic       err, err_seen, wrap, locked;
    logic [7:0] err_count, wrap_count;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // counter being watched (its true value, before any fault is shown)
    logic [3:0] ctr = 4'd0;

    // behavioural model of the monitor
    int m_phase = 0;
    int m_prev = 0;
    int m_prev_en = 0;
    int m_errs = 0;
    int m_wraps = 0;
    bit m_err = 0;
    bit m_wrap = 0;
    bit m_seen = 0;

    sync_counter_monitor #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count(count),
        .err(err), .err_seen(err_seen), .err_count(err_count),
        .wrap(wrap), .wrap_count(wrap_count),
        .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] want();
        logic [7:0] e8, w8;
        e8 = 8'(m_errs);
        w8 = 8'(m_wraps);
        return {m_err, m_seen, e8, m_wrap, w8,
                (m_phase == 1), 2'(m_phase)};
    endfunction

    function automatic logic [21:0] got();
        return {err, err_seen, err_count, wrap, wrap_count, locked, state};
    endfunction

    task automatic model_edge(input bit r, input bit e, input int c);
        int expv;
        if (r) begin
            m_phase = 0; m_prev = 0; m_prev_en = 0;
            m_errs = 0; m_wraps = 0;
            m_err = 0; m_wrap = 0; m_seen = 0;
            return;
        end
        m_err = 0;
        m_wrap = 0;
        expv = (m_prev + m_prev_en) % 16;
        if (m_phase == 0) begin
            if (c != 0) begin
                m_err = 1; m_seen = 1;
                m_errs = (m_errs < 255) ? m_errs + 1 : 255;
            end
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (c != expv) begin
                m_err = 1; m_seen = 1;
                m_errs = (m_errs < 255) ? m_errs + 1 : 255;
                m_phase = 2;
            end else if (m_prev_en == 1 && m_prev == 15) begin
                m_wrap = 1;
                m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
            end
        end else begin
            m_phase = 1;
        end
        m_prev = c;
        m_prev_en = e ? 1 : 0;
    endtask

    // called at a negedge; returns at the following negedge
    task automatic step(input bit r, input bit e, input bit f,
                        input logic [3:0] fv);
        reset = r;
        en = e;
        count = f ? fv : ctr;
        @(posedge clk);
        model_edge(r, e, int'(count));
        ctr = r ? 4'd0 : (e ? 4'(ctr + 1) : ctr);
        @(negedge clk);
    endtask

    function automatic logic [3:0] bad_of(input logic [3:0] v);
        return 4'(v + 4'(1 + $urandom_range(0, 14)));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 1), 0, 0);
        n_checks++;
        if (got() !== 22'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want 0", got());
        end
    endtask

    task automatic test_count_wrap();
        logic exp_wrap;
        test_reset();
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0);
            exp_wrap = (i > 0) && (count == 4'd0);
            n_checks++;
            if (wrap !== exp_wrap || locked !== 1'b1 || got() !== want()) begin
                n_errors++;
                $display("FAIL count_wrap cyc %0d: got %h want %h wrap %b/%b",
                         i, got(), want(), wrap, exp_wrap);
            end
        end
        n_checks++;
        if (err_count !== 8'd0 || wrap_count !== 8'd2) begin
            n_errors++;
            $display("FAIL count_wrap_tally: err %0d wrap %0d want 0 2",
                     err_count, wrap_count);
        end
    endtask

    task automatic test_hold();
        test_reset();
        while (ctr != 4'd5) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (count !== 4'd5 || err !== 1'b0 || got() !== want()) begin
                n_errors++;
                $display("FAIL hold cyc %0d: count %0d got %h want %h",
                         i, count, got(), want());
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (count !== 4'(5 + i) || got() !== want()) begin
                n_errors++;
                $display("FAIL resume cyc %0d: count %0d got %h want %h",
                         i, count, got(), want());
            end
        end
        n_checks++;
        if (err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL hold_errs: got %0d want 0", err_count);
        end
    endtask

    task automatic test_glitch();
        test_reset();
        while (ctr != 4'd4) step(0, 1, 0, 0);
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++;
            $display("FAIL glitch_pre_state: got %0d want 1", state);
        end
        step(0, 1, 1, 4'd9);
        n_checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || err_seen !== 1'b1 ||
            state !== 2'd2 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_hit: got %h want err=1 cnt=1 state=2",
                     got());
        end
        step(0, 1, 0, 0);
        n_checks++;
        if (err !== 1'b0 || state !== 2'd1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_resync: got %h want err=0 state=1", got());
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (err !== 1'b0 || err_count !== 8'd1 || got() !== want()) begin
                n_errors++;
                $display("FAIL glitch_after cyc %0d: got %h want %h",
                         i, got(), want());
            end
        end
    endtask

    task automatic test_bad_wrap();
        test_reset();
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 4'd1);
        n_checks++;
        if (err !== 1'b1 || wrap !== 1'b0 || wrap_count !== 8'd1) begin
            n_errors++;
            $display("FAIL bad_wrap: err %b wrap %b wcnt %0d want 1 0 1",
                     err, wrap, wrap_count);
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            step(0, 1, 1, bad_of(ctr));
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        while (ctr != 4'd11) step(0, 1, 0, 0);
        n_checks++;
        if (err_count !== 8'd3 || err_seen !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_pre: errs %0d want 3", err_count);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if (got() !== 22'd0) begin
            n_errors++;
            $display("FAIL mid_reset_clear: got %h want 0", got());
        end
        step(0, 1, 0, 0);
        n_checks++;
        if (state !== 2'd1 || err !== 1'b0 || err_seen !== 1'b0 ||
            got() !== want()) begin
            n_errors++;
            $display("FAIL mid_reset_relock: got %h want %h", got(), want());
        end
    endtask

    task automatic test_saturate();
        int missed;
        missed = 0;
        test_reset();
        for (int k = 0; k < 300; k++) begin
            step(0, 1, 1, bad_of(ctr));
            if (err !== 1'b1) missed++;
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        n_checks++;
        if (missed != 0) begin
            n_errors++;
            $display("FAIL sat_pulses: missed %0d want 0", missed);
        end
        n_checks++;
        if (err_count !== 8'd255 || err_seen !== 1'b1 || got() !== want()) begin
            n_errors++;
            $display("FAIL sat_count: got %0d want 255", err_count);
        end
    endtask

    task automatic test_random();
        bit r, e, f;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            e = $urandom_range(0, 3) != 0;
            f = ($urandom_range(0, 7) == 0);
            step(r, e, f, bad_of(ctr));
            n_checks++;
            if (got() !== want()) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, got(), want());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count_wrap();
        test_hold();
        test_glitch();
        test_bad_wrap();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_counter_monitor.md
# sync_counter_monitor

Passive checker that sits beside a synchronous enable counter and consumes its `count` output. Each clock it predicts the counter's next value from the previously sampled count and enable. It flags any deviation, resynchronises to the observed value, and keeps saturating tallies of errors and wrap-arounds. It is the receive side of the counter's `en`/`count` interface, used in simulation benches and as an optional on-chip health monitor.

## Interface
- `WIDTH`, default 4: width of the monitored count.
- `CNT_W`, default 8: width of the error and wrap tallies.
- `clk` in 1: clock; all sampling on the rising edge.
- `reset` in 1: synchronous, active-high; clears the monitor. It is shared with the monitored counter.
- `en` in 1: the counter's enable, as driven to the counter.
- `count` in WIDTH: the counter's output.
- `err` out 1: one-cycle pulse on a mismatch.
- `err_seen` out 1: sticky; set on the first mismatch and cleared only by `reset`.
- `err_count` out CNT_W: number of mismatches; saturates at all-ones.
- `wrap` out 1: one-cycle pulse on a correct wrap from max to 0.
- `wrap_count` out CNT_W: number of correct wraps; saturates at all-ones.
- `locked` out 1: high while the state is CHECK.
- `state` out 2: IDLE = 0, CHECK = 1, RESYNC = 2.

## Operation
- Reference model of the monitored counter at each edge:
  - `reset` = 1 gives 0.
  - Otherwise `en` = 1 gives `count` + 1, modulo 2^WIDTH.
  - Otherwise `count` holds.
- Internal registers: `ref_cnt` (WIDTH bits), the last sampled count, and `ref_en`, the last sampled `en`.
- Expected value: `exp` = `ref_en` ? `ref_cnt` + 1 : `ref_cnt`, truncated to WIDTH bits, so 2^WIDTH - 1 + 1 = 0.
- Reset edge (`reset` = 1):
  - State goes to IDLE.
  - All outputs and `ref_*` clear to 0.
  - `reset` takes priority over everything else.
- IDLE, first edge with `reset` = 0:
  - `count` must equal 0, since the counter was reset alongside the monitor.
  - If `count` != 0, pulse `err`, increment `err_count` and set `err_seen`.
  - In either case capture `ref_cnt` <= `count` and `ref_en` <= `en`, then go to CHECK.
- CHECK, each edge:
  - Compare `count` with `exp`.
  - Match: stay in CHECK.
    - If `ref_en` = 1 and `ref_cnt` = all-ones, also pulse `wrap` and increment `wrap_count`.
  - Mismatch: pulse `err`, increment `err_count`, set `err_seen`, go to RESYNC.
  - Always capture `ref_cnt` <= `count` and `ref_en` <= `en`.
- RESYNC, one edge:
  - No comparison is made and no `err` is raised.
  - Capture `ref_*` from the inputs, then return to CHECK.
  - Purpose: one bad value produces exactly one error, not two.
- Tallies never roll over: at all-ones they hold.
- `err` and `wrap` never assert in the same cycle; a wrong wrap counts as an error only.
- A hold while `en` = 0 is a valid match, not an error.

## Timing
- All outputs are registered; none is combinational from the inputs.
- `err` and `wrap` are high for exactly the cycle after the edge that sampled the offending or wrapping value.
- Detection latency: a bad `count` present before edge k gives `err` = 1 in the cycle after edge k.
- An `en` change is honoured with one cycle of lag, matching the counter: `en` sampled at edge k sets the expectation checked at edge k+1.
- Reset mid-operation: the edge with `reset` = 1 clears everything, including `err_seen` and the tallies. The next non-reset edge follows the IDLE rules.
- `reset` held for several cycles: the monitor stays in IDLE with all outputs 0.
- `locked` falls in the cycle after a mismatch edge and rises again one cycle later.

## Test plan
Bench settings: WIDTH = 4, CNT_W = 8, 10-unit clock period, monitor driven by a correct counter unless stated otherwise.

1. Reset for 3 edges, then `en` = 1 for 40 cycles.
   - Required: `err_count` = 0, `wrap_count` = 2, `wrap` pulses exactly on the 15 -> 0 transitions, `locked` = 1 from the 2nd post-reset cycle onward.
2. `en` = 1 to count 5, then `en` = 0 for 10 cycles, then `en` = 1 again.
   - Required: `count` holds at 5 with no `err`, then counting resumes 6, 7, ... with `err_count` = 0.
3. Force `count` to 9 for one cycle where 4 is expected, then release.
   - Required: exactly one `err` pulse, `err_count` = 1, `err_seen` = 1, `state` sequence CHECK -> RESYNC -> CHECK.
   - No second error when the counter resumes from 5.
4. Counter that wraps 15 -> 1 (a skip).
   - Required: `err` = 1, `wrap` = 0, `wrap_count` unchanged.
5. Assert `reset` for one edge mid-count at `count` = 11, after `err_count` = 3.
   - Required: all outputs 0 the next cycle, `state` = IDLE, then CHECK. `err_seen` = 0.
6. Inject 300 errors.
   - Required: `err_count` saturates at 255, and `err` still pulses on each error.
